// File: rtl/combo_pkg.sv
// ---------------------------------------------------------------------------
// combo_pkg
// Shared definitions for the combination-entry front end of the lock
// datapath.
//   DIGIT_W   : width of one combination digit
//   COMBO_MOD : modulus of the digit domain (0..COMBO_MOD-1). The downstream
//               sum/average/offset ALU uses the same modulus.
//   state_t   : entry sequencer states
//   dial_up / dial_dn : wrap-around dial stepping
// ---------------------------------------------------------------------------
package combo_pkg;

  localparam int DIGIT_W   = 5;
  localparam int COMBO_MOD = 30;

  typedef enum logic [2:0] {
    DIG0   = 3'd0,
    DIG1   = 3'd1,
    DIG2   = 3'd2,
    SETTLE = 3'd3,
    LOADP  = 3'd4
  } state_t;

  // Step the dial up by one, wrapping from max back to zero.
  function automatic logic [DIGIT_W-1:0] dial_up(input logic [DIGIT_W-1:0] value,
                                                 input logic [DIGIT_W-1:0] max);
    return (value == max) ? '0 : value + DIGIT_W'(1);
  endfunction

  // Step the dial down by one, wrapping from zero to max.
  function automatic logic [DIGIT_W-1:0] dial_dn(input logic [DIGIT_W-1:0] value,
                                                 input logic [DIGIT_W-1:0] max);
    return (value == '0) ? max : value - DIGIT_W'(1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Conditions one raw, asynchronous push-button into a single-cycle press
// pulse. The input is synchronised through two flops; the accepted level
// only follows the synchronised level after DEBOUNCE_CYC consecutive cycles
// of disagreement. A pulse is produced on each accepted rising edge only.
//
// Ports:
//   CLK   in   clock
//   RST   in   synchronous, active-high reset
//   btn   in   raw button level
//   press out  one-cycle pulse per debounced press (registered)
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] stable_cnt;

  // The counter is cleared whenever the input agrees with the accepted level,
  // so only an unbroken run of DEBOUNCE_CYC disagreeing cycles flips it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level      <= sync2;
        stable_cnt <= '0;
        press      <= sync2;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/combo_entry.sv
// ---------------------------------------------------------------------------
// combo_entry
// Front-end sequencer for the lock datapath. Four debounced buttons drive a
// mod-(DIAL_MAX+1) dial; three ENTER presses capture three digits, which are
// committed together onto A/B/C. After LOAD_DELAY cycles for the ALU adder and
// divider stages to settle, a one-cycle LOAD seeds the downstream LFSR.
// A partial entry is abandoned by CLR or after TIMEOUT_CYC idle cycles.
// Digit width DIGIT_W comes from combo_pkg. LOAD_DELAY must be at least 1.
//
// Ports:
//   CLK        in   clock
//   RST        in   synchronous, active-high reset
//   BTN_UP     in   raw button, increment dial
//   BTN_DN     in   raw button, decrement dial
//   BTN_ENTER  in   raw button, capture dial as next digit
//   BTN_CLR    in   raw button, abandon entry
//   A, B, C    out  committed digits 0, 1, 2
//   LOAD       out  one-cycle pulse to the LFSR LOAD
//   DIAL       out  current dial value for display
//   DIGIT_IDX  out  digit being entered (0..2), 3 while settling/loading
//   BUSY       out  high while settling/loading
// ---------------------------------------------------------------------------
module combo_entry
  import combo_pkg::*;
#(
  parameter int DIAL_MAX     = COMBO_MOD - 1,
  parameter int DEBOUNCE_CYC = 4,
  parameter int LOAD_DELAY   = 2,
  parameter int TIMEOUT_CYC  = 1000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               BTN_UP,
  input  logic               BTN_DN,
  input  logic               BTN_ENTER,
  input  logic               BTN_CLR,
  output logic [DIGIT_W-1:0] A,
  output logic [DIGIT_W-1:0] B,
  output logic [DIGIT_W-1:0] C,
  output logic               LOAD,
  output logic [DIGIT_W-1:0] DIAL,
  output logic [1:0]         DIGIT_IDX,
  output logic               BUSY
);

  localparam int SET_W  = $clog2(LOAD_DELAY + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DIGIT_W-1:0] DIAL_TOP = DIGIT_W'(DIAL_MAX);

  state_t              state;
  state_t              next_state;

  logic                up_p;
  logic                dn_p;
  logic                ent_p;
  logic                clr_p;

  logic [DIGIT_W-1:0]  dial;
  logic [DIGIT_W-1:0]  d0;
  logic [DIGIT_W-1:0]  d1;
  logic [SET_W-1:0]    settle_cnt;
  logic [IDLE_W-1:0]   idle_cnt;

  logic                active;
  logic                any_pulse;
  logic                idle_run;
  logic                timeout_hit;
  logic                do_clr;
  logic                do_ent;
  logic                do_up;
  logic                do_dn;
  logic                settle_done;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
    .CLK   (CLK),
    .RST   (RST),
    .btn   (BTN_UP),
    .press (up_p)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
    .CLK   (CLK),
    .RST   (RST),
    .btn   (BTN_DN),
    .press (dn_p)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_enter (
    .CLK   (CLK),
    .RST   (RST),
    .btn   (BTN_ENTER),
    .press (ent_p)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clr (
    .CLK   (CLK),
    .RST   (RST),
    .btn   (BTN_CLR),
    .press (clr_p)
  );

  // Pulses are only honoured in the entry states; anything arriving while
  // settling or loading is dropped rather than queued.
  // Priority: CLR (or timeout) > ENTER > UP/DN, and UP with DN cancels.
  // The idle counter runs only while there is a partial entry to lose.
  always_comb begin
    active      = (state == DIG0) || (state == DIG1) || (state == DIG2);
    any_pulse   = active && (up_p || dn_p || ent_p || clr_p);
    idle_run    = (state == DIG1) || (state == DIG2) ||
                  ((state == DIG0) && (dial != '0));
    timeout_hit = idle_run && !any_pulse &&
                  (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));
    do_clr      = active && (clr_p || timeout_hit);
    do_ent      = active && ent_p && !clr_p;
    do_up       = active && up_p && !dn_p && !ent_p && !clr_p;
    do_dn       = active && dn_p && !up_p && !ent_p && !clr_p;
    settle_done = (state == SETTLE) &&
                  (settle_cnt == SET_W'(LOAD_DELAY - 1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= DIG0;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      DIG0: begin
        if (do_clr) begin
          next_state = DIG0;
        end else if (do_ent) begin
          next_state = DIG1;
        end
      end
      DIG1: begin
        if (do_clr) begin
          next_state = DIG0;
        end else if (do_ent) begin
          next_state = DIG2;
        end
      end
      DIG2: begin
        if (do_clr) begin
          next_state = DIG0;
        end else if (do_ent) begin
          next_state = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_done) begin
          next_state = LOADP;
        end
      end
      LOADP: begin
        next_state = DIG0;
      end
      default: begin
        next_state = DIG0;
      end
    endcase
  end

  always_comb begin
    LOAD      = 1'b0;
    BUSY      = 1'b0;
    DIGIT_IDX = 2'd3;
    case (state)
      DIG0:    DIGIT_IDX = 2'd0;
      DIG1:    DIGIT_IDX = 2'd1;
      DIG2:    DIGIT_IDX = 2'd2;
      SETTLE:  BUSY = 1'b1;
      LOADP: begin
        BUSY = 1'b1;
        LOAD = 1'b1;
      end
      default: DIGIT_IDX = 2'd3;
    endcase
  end

  // Digits are staged in d0/d1 and only copied to A/B/C together with the
  // third digit, so the ALU never sees a half-updated combination.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dial <= '0;
      d0   <= '0;
      d1   <= '0;
      A    <= '0;
      B    <= '0;
      C    <= '0;
    end else if (do_clr) begin
      dial <= '0;
      d0   <= '0;
      d1   <= '0;
    end else if (do_ent) begin
      dial <= '0;
      case (state)
        DIG0: d0 <= dial;
        DIG1: d1 <= dial;
        DIG2: begin
          A <= d0;
          B <= d1;
          C <= dial;
        end
        default: begin
        end
      endcase
    end else if (do_up) begin
      dial <= dial_up(dial, DIAL_TOP);
    end else if (do_dn) begin
      dial <= dial_dn(dial, DIAL_TOP);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      settle_cnt <= '0;
    end else if (do_ent && (state == DIG2)) begin
      settle_cnt <= '0;
    end else if (state == SETTLE) begin
      settle_cnt <= settle_cnt + SET_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idle_cnt <= '0;
    end else if (!idle_run || any_pulse || do_clr) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  assign DIAL = dial;

endmodule

// File: tb/tb_combo_entry.sv
// ---------------------------------------------------------------------------
// tb_combo_entry
// Self-checking bench for combo_entry. A behavioural model (dial as an
// integer mod 30, entered digits as a queue) predicts the effect of every
// button press; committed combinations are pushed to a scoreboard queue and
// a monitor pops and compares them whenever the DUT raises LOAD.
// ---------------------------------------------------------------------------
module tb_combo_entry;

  localparam int MOD          = 30;
  localparam int DIAL_MAX     = MOD - 1;
  localparam int DEBOUNCE_CYC = 4;
  localparam int LOAD_DELAY   = 2;
  localparam int TIMEOUT_CYC  = 1000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_UP = 1'b0;
  logic       BTN_DN = 1'b0;
  logic       BTN_ENTER = 1'b0;
  logic       BTN_CLR = 1'b0;
  logic [4:0] A;
  logic [4:0] B;
  logic [4:0] C;
  logic       LOAD;
  logic [4:0] DIAL;
  logic [1:0] DIGIT_IDX;
  logic       BUSY;

  int errors = 0;
  int checks = 0;

  int m_dial = 0;
  int m_digits[$];
  int m_a = 0;
  int m_b = 0;
  int m_c = 0;

  logic [14:0] exp_q[$];
  int busy_cycles = 0;

  combo_entry #(
    .DIAL_MAX     (DIAL_MAX),
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .LOAD_DELAY   (LOAD_DELAY),
    .TIMEOUT_CYC  (TIMEOUT_CYC)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BTN_UP    (BTN_UP),
    .BTN_DN    (BTN_DN),
    .BTN_ENTER (BTN_ENTER),
    .BTN_CLR   (BTN_CLR),
    .A         (A),
    .B         (B),
    .C         (C),
    .LOAD      (LOAD),
    .DIAL      (DIAL),
    .DIGIT_IDX (DIGIT_IDX),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: what the lock should do for one accepted press.
  task automatic model_press(input bit up, input bit dn, input bit ent, input bit clr);
    if (clr) begin
      m_dial = 0;
      m_digits.delete();
    end else if (ent) begin
      m_digits.push_back(m_dial);
      m_dial = 0;
      if (m_digits.size() == 3) begin
        m_a = m_digits[0];
        m_b = m_digits[1];
        m_c = m_digits[2];
        exp_q.push_back({5'(m_a), 5'(m_b), 5'(m_c)});
        m_digits.delete();
      end
    end else if (up && !dn) begin
      m_dial = (m_dial + 1) % MOD;
    end else if (dn && !up) begin
      m_dial = (m_dial + MOD - 1) % MOD;
    end
  endtask

  task automatic model_reset();
    m_dial = 0;
    m_digits.delete();
    m_a = 0;
    m_b = 0;
    m_c = 0;
  endtask

  task automatic check_output(input string tag);
    check_val({tag, "_dial"}, int'(DIAL), m_dial);
    check_val({tag, "_idx"}, int'(DIGIT_IDX), m_digits.size());
    check_val({tag, "_busy"}, int'(BUSY), 0);
    check_val({tag, "_a"}, int'(A), m_a);
    check_val({tag, "_b"}, int'(B), m_b);
    check_val({tag, "_c"}, int'(C), m_c);
  endtask

  // Expected result is queued before the buttons move, then the press is
  // held long enough to debounce, released, and the outputs compared.
  task automatic apply_stimulus(input bit up, input bit dn, input bit ent, input bit clr,
                                input int hold, input string tag);
    model_press(up, dn, ent, clr);
    @(negedge CLK);
    BTN_UP    = up;
    BTN_DN    = dn;
    BTN_ENTER = ent;
    BTN_CLR   = clr;
    repeat (hold) @(negedge CLK);
    BTN_UP    = 1'b0;
    BTN_DN    = 1'b0;
    BTN_ENTER = 1'b0;
    BTN_CLR   = 1'b0;
    repeat (12) @(negedge CLK);
    check_output(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_a"}, int'(A), 0);
    check_val({tag, "_b"}, int'(B), 0);
    check_val({tag, "_c"}, int'(C), 0);
    check_val({tag, "_load"}, int'(LOAD), 0);
    check_val({tag, "_dial"}, int'(DIAL), 0);
    check_val({tag, "_idx"}, int'(DIGIT_IDX), 0);
    check_val({tag, "_busy"}, int'(BUSY), 0);
  endtask

  // Monitor: every LOAD must match the oldest queued combination and land
  // on the (LOAD_DELAY+1)th busy cycle after the commit.
  always @(negedge CLK) begin : monitor
    logic [14:0] exp_abc;
    if (RST || !BUSY) begin
      busy_cycles = 0;
    end else begin
      busy_cycles++;
    end
    if (LOAD) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL load_unexpected: LOAD=1 with A=%0d B=%0d C=%0d, expected no LOAD",
                 A, B, C);
      end else begin
        exp_abc = exp_q.pop_front();
        check_val("load_abc", int'({A, B, C}), int'(exp_abc));
        check_val("load_latency", busy_cycles, LOAD_DELAY + 1);
        check_val("load_idx", int'(DIGIT_IDX), 3);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int r;
    int hold;
    bit found;

    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Main sequence: 3, 29 (via wrap below zero), 29
    repeat (3) apply_stimulus(1, 0, 0, 0, 6, "seq_up");
    apply_stimulus(0, 0, 1, 0, 6, "seq_ent0");
    apply_stimulus(0, 1, 0, 0, 6, "seq_dn");
    apply_stimulus(0, 0, 1, 0, 6, "seq_ent1");
    repeat (29) apply_stimulus(1, 0, 0, 0, 6, "seq_up29");
    apply_stimulus(0, 0, 1, 0, 6, "seq_commit");

    // Dial wrap and simultaneous UP/DN
    apply_stimulus(0, 1, 0, 0, 6, "wrap_dn");
    apply_stimulus(1, 0, 0, 0, 6, "wrap_up");
    apply_stimulus(0, 1, 0, 0, 6, "wrap_dn2");
    apply_stimulus(1, 1, 0, 0, 6, "updn_same");
    apply_stimulus(1, 0, 0, 0, 6, "wrap_up2");

    // Two digits then CLR: previous combination must survive
    repeat (5) apply_stimulus(1, 0, 0, 0, 6, "clr_up5");
    apply_stimulus(0, 0, 1, 0, 6, "clr_ent0");
    repeat (7) apply_stimulus(1, 0, 0, 0, 6, "clr_up7");
    apply_stimulus(0, 0, 1, 0, 6, "clr_ent1");
    repeat (2) apply_stimulus(1, 0, 0, 0, 6, "clr_up2");
    apply_stimulus(0, 0, 0, 1, 6, "clr");

    // Glitch shorter than the debounce window, then a long hold
    @(negedge CLK);
    BTN_UP = 1'b1;
    repeat (2) @(negedge CLK);
    BTN_UP = 1'b0;
    repeat (12) @(negedge CLK);
    check_output("glitch");
    apply_stimulus(1, 0, 0, 0, 10, "hold10");

    // Pulses landing in SETTLE are ignored: UP and CLR one cycle behind ENTER
    apply_stimulus(0, 0, 1, 0, 6, "settle_ent0");
    apply_stimulus(1, 0, 0, 0, 6, "settle_up");
    apply_stimulus(0, 0, 1, 0, 6, "settle_ent1");
    repeat (4) apply_stimulus(1, 0, 0, 0, 6, "settle_up4");
    model_press(0, 0, 1, 0);
    @(negedge CLK);
    BTN_ENTER = 1'b1;
    @(negedge CLK);
    BTN_UP  = 1'b1;
    BTN_CLR = 1'b1;
    repeat (8) @(negedge CLK);
    BTN_ENTER = 1'b0;
    BTN_UP    = 1'b0;
    BTN_CLR   = 1'b0;
    repeat (14) @(negedge CLK);
    check_output("settle_ignore");

    // Timeout in DIG1
    repeat (2) apply_stimulus(1, 0, 0, 0, 6, "to_up");
    apply_stimulus(0, 0, 1, 0, 6, "to_ent");
    repeat (880) @(negedge CLK);
    check_val("timeout_early_idx", int'(DIGIT_IDX), 1);
    repeat (200) @(negedge CLK);
    m_digits.delete();
    m_dial = 0;
    check_output("timeout_dig1");

    // Timeout in DIG0 with a non-zero dial
    apply_stimulus(1, 0, 0, 0, 6, "to0_up");
    repeat (TIMEOUT_CYC + 100) @(negedge CLK);
    m_dial = 0;
    check_output("timeout_dig0");

    // Randomised presses against the model
    for (int i = 0; i < 80; i++) begin
      r    = int'($urandom_range(0, 99));
      hold = int'($urandom_range(5, 10));
      if (r < 40)      apply_stimulus(1, 0, 0, 0, hold, "rnd_up");
      else if (r < 68) apply_stimulus(0, 1, 0, 0, hold, "rnd_dn");
      else if (r < 73) apply_stimulus(1, 1, 0, 0, hold, "rnd_updn");
      else if (r < 95) apply_stimulus(0, 0, 1, 0, hold, "rnd_ent");
      else             apply_stimulus(0, 0, 0, 1, hold, "rnd_clr");
    end

    // Reset during SETTLE: no LOAD, everything back to zero
    apply_stimulus(0, 0, 0, 1, 6, "rst_clr");
    apply_stimulus(1, 0, 0, 0, 6, "rst_up");
    apply_stimulus(0, 0, 1, 0, 6, "rst_ent0");
    apply_stimulus(0, 0, 1, 0, 6, "rst_ent1");
    apply_stimulus(1, 0, 0, 0, 6, "rst_up2");
    @(negedge CLK);
    BTN_ENTER = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (BUSY) begin
        found = 1'b1;
        break;
      end
    end
    check_val("rst_settle_reached", int'(found), 1);
    RST       = 1'b1;
    BTN_ENTER = 1'b0;
    @(negedge CLK);
    check_all_zero("rst_settle");
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    model_reset();
    repeat (20) @(negedge CLK);
    check_output("post_reset");

    check_val("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/combo_entry.md
Name: combo_entry

Overview:
- Front-end sequencer for the lock datapath. Turns four raw push-buttons (UP, DN, ENTER, CLR) into a three-digit combination.
- Each digit is 0..29 (mod-30 domain, matching the downstream sum/average/offset ALU).
- Commits the three digits together onto A/B/C, waits for the ALU's adder and divider stages to settle, then issues a one-cycle LOAD to seed the LFSR.

Parameters:
- DIGIT_W, 5, width of each digit and of A/B/C.
- DIAL_MAX, 29, largest dial value; the dial wraps modulo DIAL_MAX+1.
- DEBOUNCE_CYC, 4, consecutive stable cycles required before a button change is accepted (bench value; set larger for board builds).
- LOAD_DELAY, 2, cycles between commit of A/B/C and the LOAD pulse; covers the adder and divider register stages.
- TIMEOUT_CYC, 1000, idle cycles after which a partial entry is abandoned.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- BTN_UP  in  1  raw asynchronous button, increment dial
- BTN_DN  in  1  raw asynchronous button, decrement dial
- BTN_ENTER  in  1  raw asynchronous button, capture dial as next digit
- BTN_CLR  in  1  raw asynchronous button, abandon entry
- A  out  DIGIT_W  committed digit 0
- B  out  DIGIT_W  committed digit 1
- C  out  DIGIT_W  committed digit 2
- LOAD  out  1  one-cycle pulse to the downstream LFSR LOAD
- DIAL  out  DIGIT_W  current dial value, for display
- DIGIT_IDX  out  2  digit being entered: 0..2; 3 while SETTLE or LOADP
- BUSY  out  1  high in SETTLE and LOADP

Behaviour:
- Reset: RST is synchronous, active-high; clock is CLK. On reset all outputs and all internal registers go to 0, and the FSM enters DIG0. Reset mid-entry or mid-SETTLE discards everything, and no LOAD is issued.
- Button conditioning: each button passes through its own debouncer instance, which produces a single-cycle press pulse per debounced rising edge. Release produces no pulse. Glitches shorter than DEBOUNCE_CYC cycles produce no pulse.
- Pulse priority within one cycle:
  - CLR beats ENTER.
  - ENTER beats UP/DN.
  - UP and DN together cause no dial change.
- Dial arithmetic:
  - UP: DIAL = (DIAL == DIAL_MAX) ? 0 : DIAL+1.
  - DN: DIAL = (DIAL == 0) ? DIAL_MAX : DIAL-1.
  - The dial never holds a value above DIAL_MAX.
- FSM states: DIG0, DIG1, DIG2, SETTLE, LOADP.
  - DIG0 + ENTER: d0 := DIAL, DIAL := 0, go to DIG1.
  - DIG1 + ENTER: d1 := DIAL, DIAL := 0, go to DIG2.
  - DIG2 + ENTER: A := d0, B := d1, C := DIAL, all in the same edge. DIAL := 0, counter := 0, go to SETTLE.
  - SETTLE: counter increments each cycle. When counter == LOAD_DELAY-1, go to LOADP.
  - LOADP: LOAD = 1 for exactly this cycle, then go to DIG0.
  - The LOAD pulse is therefore the (LOAD_DELAY+1)th cycle after the commit edge.
  - A/B/C change only at the DIG2 commit. They hold through the next entry until the following commit.
- CLR in DIG0..DIG2: DIAL := 0, d0 := d1 := 0, go to DIG0. A/B/C are unchanged.
- Timeout:
  - An idle counter resets on any accepted pulse.
  - While in DIG1 or DIG2, or in DIG0 with DIAL != 0, it increments each cycle.
  - On reaching TIMEOUT_CYC it behaves exactly as CLR.
  - It never runs in SETTLE or LOADP.
- Button pulses arriving during SETTLE or LOADP are ignored; they are not queued.
- DIGIT_IDX reflects the state for the current cycle. BUSY = (state == SETTLE or LOADP).

Decomposition:
- Shared package combo_pkg holds:
  - the state enum (DIG0..LOADP);
  - DIGIT_W = 5;
  - COMBO_MOD = 30, which is also the reference constant for the ALU modular arithmetic.
- One sub-module, btn_debounce, instanced four times:
  - 2-flop synchroniser;
  - stability counter, cleared whenever the synchronised level equals the accepted level;
  - accepted level toggles after DEBOUNCE_CYC consecutive mismatching cycles;
  - registered rising-edge pulse output.

Test Plan:
- Reset, then UP x3, ENTER, DN x1, ENTER, UP x29, ENTER -> A=3, B=29, C=29; LOAD high exactly one cycle, LOAD_DELAY+1 cycles after commit; DIGIT_IDX sequence 0,1,2,3,0.
- DIAL=29 plus UP -> DIAL=0; DIAL=0 plus DN -> DIAL=29; UP and DN pressed in the same cycle -> DIAL unchanged.
- Enter 5 and 7, then CLR before the third digit -> state DIG0, DIAL=0, A/B/C still hold the previous committed combination, no LOAD.
- 2-cycle glitch on BTN_UP with DEBOUNCE_CYC=4 -> DIAL unchanged; a 10-cycle hold -> exactly one increment.
- In DIG1, no presses for TIMEOUT_CYC cycles -> DIGIT_IDX returns to 0 and d0 is cleared. ENTER pressed during SETTLE -> ignored, and the next entry starts at DIG0 with DIAL=0.
- RST asserted during SETTLE -> no LOAD pulse; all outputs 0 on the next cycle.
